// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage of the pipelined RV32 core. Owns the
//                program counter, drives the combinational instruction memory
//                and fills the IF/ID pipeline register. Supports decode stalls,
//                branch/jump redirects with a single flush bubble, and halts on
//                an all-zero word or an out-of-range PC.
//  Ports       :
//    clk              in   system clock, rising edge
//    rst              in   asynchronous active-high reset
//    stall            in   hold PC and IF/ID contents
//    redirect_valid   in   taken branch/jump resolved downstream
//    redirect_target  in   [31:0] new byte PC (low two bits dropped)
//    imem_addr        out  [31:0] byte address to instruction memory (= pc)
//    imem_instr       in   [31:0] instruction word for imem_addr
//    if_id_instr      out  [31:0] registered instruction to decode
//    if_id_pc         out  [31:0] registered PC of if_id_instr
//    if_id_valid      out  if_id_instr is a real instruction (0 = bubble)
//    halted           out  fetch has stopped
//    fetch_count      out  [31:0] number of valid instructions delivered
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // Memory size in bytes, held in 33 bits so a 4 GiB memory still compares
  // correctly against the full 32-bit pc.
  localparam logic [32:0] c_MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;

  logic        w_out_of_range;
  logic        w_end_of_prog;

  assign w_out_of_range = ({1'b0, pc_q} >= c_MEM_BYTES);
  assign w_end_of_prog  = (imem_instr == 32'h0000_0000);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (redirect_valid) begin
      // Redirect beats stall: flush the slot and clear any halt. Masking keeps
      // the target word-aligned.
      pc_d    = redirect_target & ~32'h0000_0003;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (stall) begin
      // Hold everything.
    end else if (state_q == ST_RUN) begin
      if (w_out_of_range || w_end_of_prog) begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_instr;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
        count_d = count_q + 32'd1;
      end
    end else begin
      valid_d = 1'b0;
    end

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      ipc_q    <= 32'h0000_0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage with a small
//                combinational instruction memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  int checks;
  int errors;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (1024)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  // Out-of-range addresses return a nonzero word so the halt must come from
  // the range check, not from an end-of-program word.
  assign imem_instr = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0000_0101 + 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 12; i++) mem[i] = word_of(i);

    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    // Reset state before any clock edge
    #2;
    check("rst_pc",      imem_addr,   32'h0);
    check("rst_valid",   {31'b0, if_id_valid}, 32'h0);
    check("rst_instr",   if_id_instr, 32'h0);
    check("rst_ifpc",    if_id_pc,    32'h0);
    check("rst_halted",  {31'b0, halted}, 32'h0);
    check("rst_count",   fetch_count, 32'h0);

    tick();
    rst = 1'b0;

    // Straight-line fetch of 12 words
    for (int i = 0; i < 12; i++) begin
      tick();
      check("run_ifpc",  if_id_pc,    32'(i * 4));
      check("run_instr", if_id_instr, word_of(i));
      check("run_valid", {31'b0, if_id_valid}, 32'h1);
      check("run_count", fetch_count, 32'(i + 1));
    end

    // Zero word at 0x30 halts
    tick();
    check("halt_flag",  {31'b0, halted}, 32'h1);
    check("halt_valid", {31'b0, if_id_valid}, 32'h0);
    check("halt_pc",    imem_addr,   32'h30);
    check("halt_count", fetch_count, 32'd12);
    tick();
    check("halt_hold_pc",   imem_addr, 32'h30);
    check("halt_hold_flag", {31'b0, halted}, 32'h1);

    // Redirect out of halt with stall asserted too: redirect wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h4;
    stall           = 1'b1;
    tick();
    check("rdh_halted", {31'b0, halted}, 32'h0);
    check("rdh_pc",     imem_addr, 32'h4);
    check("rdh_valid",  {31'b0, if_id_valid}, 32'h0);
    check("rdh_ifpc",   if_id_pc,  32'h2C);
    check("rdh_count",  fetch_count, 32'd12);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();
    check("resume_ifpc",  if_id_pc, 32'h4);
    check("resume_valid", {31'b0, if_id_valid}, 32'h1);
    check("resume_count", fetch_count, 32'd13);
    check("resume_pc",    imem_addr, 32'h8);

    // Stall for 3 cycles at pc=0x08
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    imem_addr, 32'h8);
      check("stall_ifpc",  if_id_pc,  32'h4);
      check("stall_valid", {31'b0, if_id_valid}, 32'h1);
      check("stall_count", fetch_count, 32'd13);
    end
    stall = 1'b0;
    tick();
    check("unstall_ifpc",  if_id_pc,    32'h8);
    check("unstall_instr", if_id_instr, word_of(2));
    check("unstall_count", fetch_count, 32'd14);
    tick();
    check("pc10", imem_addr, 32'h10);
    check("ifpc0c", if_id_pc, 32'hC);

    // Misaligned redirect at pc=0x10
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_001A;
    tick();
    check("rd_pc",    imem_addr, 32'h18);
    check("rd_valid", {31'b0, if_id_valid}, 32'h0);
    check("rd_ifpc",  if_id_pc,  32'hC);
    check("rd_count", fetch_count, 32'd15);
    redirect_valid = 1'b0;
    tick();
    check("rd2_ifpc",  if_id_pc,    32'h18);
    check("rd2_instr", if_id_instr, word_of(6));
    check("rd2_valid", {31'b0, if_id_valid}, 32'h1);
    check("rd2_count", fetch_count, 32'd16);
    tick();
    check("pre_rst_pc", imem_addr, 32'h20);
    check("pre_rst_count", fetch_count, 32'd17);

    // Asynchronous reset mid-run, checked before any clock edge
    #1;
    rst = 1'b1;
    #1;
    check("arst_pc",     imem_addr,   32'h0);
    check("arst_valid",  {31'b0, if_id_valid}, 32'h0);
    check("arst_count",  fetch_count, 32'h0);
    check("arst_halted", {31'b0, halted}, 32'h0);
    // Redirect while reset is held has no effect
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    check("arst_rd_pc", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    rst            = 1'b0;
    tick();
    check("restart_ifpc",  if_id_pc,    32'h0);
    check("restart_instr", if_id_instr, word_of(0));
    check("restart_count", fetch_count, 32'd1);
    check("restart_pc",    imem_addr,   32'h4);

    // Redirect to first out-of-range address
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_1000;
    tick();
    check("oor_pc",     imem_addr, 32'h1000);
    check("oor_halted", {31'b0, halted}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    check("oor_halt",   {31'b0, halted}, 32'h1);
    check("oor_valid",  {31'b0, if_id_valid}, 32'h0);
    check("oor_count",  fetch_count, 32'd1);
    check("oor_pc2",    imem_addr, 32'h1000);
    check("oor_ifpc",   if_id_pc,  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
